// File: rtl/rfdc_dds_driver_if.sv
// AXI-Stream style sample bus between the DDS driver and the RF data converter.
// The driver is the master: it presents packed sample beats and the converter
// side answers with tready.
interface rfdc_dds_driver_if #(
   parameter int DATA_WIDTH        = 16,
   parameter int SAMPLES_PER_CYCLE = 5
);
   logic [DATA_WIDTH*SAMPLES_PER_CYCLE-1:0] s_axis_tdata;
   logic                                    s_axis_tvalid;
   logic                                    s_axis_tready;

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready
   );

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready
   );
endinterface

// File: rtl/rfdc_dds_driver.sv
// Direct digital synthesis driver for an RF data converter.
// Each beat packs SAMPLES_PER_CYCLE consecutive samples. In sine mode they come
// from a quarter-wave-free full sine table addressed by the top bits of a phase
// accumulator, scaled by a gain; in ramp mode they form a free-running counter.
// Configuration is captured into a shadow register and only ever consumed at a
// beat load, so a beat is never built from a half-updated configuration.
module rfdc_dds_driver #(
   parameter int DATA_WIDTH        = 16,
   parameter int SAMPLES_PER_CYCLE = 5,
   parameter int LUT_DEPTH         = 64,
   parameter int PHASE_WIDTH       = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   cfg_valid,
   input  logic [PHASE_WIDTH-1:0] cfg_freq_word,
   input  logic [DATA_WIDTH-1:0]  cfg_amp,
   input  logic                   cfg_mode,
   rfdc_dds_driver_if.master      axis,
   output logic [31:0]            beat_count
);

   localparam int ADDR_WIDTH = $clog2(LUT_DEPTH);
   localparam int BEAT_WIDTH = DATA_WIDTH * SAMPLES_PER_CYCLE;
   localparam logic [DATA_WIDTH-1:0] UNITY_GAIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Sine table built at elaboration; $rtoi truncates toward zero.
   function automatic logic [LUT_DEPTH*DATA_WIDTH-1:0] build_sine_lut();
      logic [LUT_DEPTH*DATA_WIDTH-1:0] table_bits;
      real                             full_scale;
      real                             value;
      table_bits = '0;
      full_scale = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
      for (int k = 0; k < LUT_DEPTH; k++) begin
         value = $sin(2.0 * 3.14159265358979323846 * k / LUT_DEPTH) * full_scale;
         table_bits[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($rtoi(value));
      end
      return table_bits;
   endfunction

   localparam logic [LUT_DEPTH*DATA_WIDTH-1:0] SINE_LUT = build_sine_lut();

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   load;
   logic                   accept;
   logic [PHASE_WIDTH-1:0] phase_q;
   logic [DATA_WIDTH-1:0]  ramp_q;
   logic [PHASE_WIDTH-1:0] base_phase;
   logic [DATA_WIDTH-1:0]  base_ramp;
   logic [PHASE_WIDTH-1:0] freq_sh;
   logic [DATA_WIDTH-1:0]  amp_sh;
   logic                   mode_sh;
   logic [DATA_WIDTH-1:0]  amp_eff;
   logic [BEAT_WIDTH-1:0]  next_beat;
   logic [BEAT_WIDTH-1:0]  tdata_q;

   assign accept = (state == RUN) && axis.s_axis_tready;

   // A fresh stream always starts from phase 0 and ramp 0, regardless of where
   // the previous stream stopped.
   assign base_phase = (state == IDLE) ? '0 : phase_q;
   assign base_ramp  = (state == IDLE) ? '0 : ramp_q;
   assign amp_eff    = (amp_sh > UNITY_GAIN) ? UNITY_GAIN : amp_sh;

   // Per-sample generation; taking the product bits [2W-2:W-1] of the two's
   // complement product is an arithmetic shift right by W-1, i.e. floor.
   for (genvar i = 0; i < SAMPLES_PER_CYCLE; i++) begin : g_sample
      logic [PHASE_WIDTH-1:0]  samp_phase;
      logic [ADDR_WIDTH-1:0]   lut_addr;
      logic [DATA_WIDTH-1:0]   lut_val;
      logic [2*DATA_WIDTH:0]   product;
      logic [DATA_WIDTH-1:0]   sine_val;
      logic [DATA_WIDTH-1:0]   ramp_val;
      logic                    unused_bits;

      assign samp_phase = base_phase + PHASE_WIDTH'(i) * freq_sh;
      assign lut_addr   = samp_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
      assign lut_val    = SINE_LUT[lut_addr*DATA_WIDTH +: DATA_WIDTH];
      assign product    = {{(DATA_WIDTH+1){lut_val[DATA_WIDTH-1]}}, lut_val}
                        * {{(DATA_WIDTH+1){1'b0}}, amp_eff};
      assign sine_val   = product[2*DATA_WIDTH-2 : DATA_WIDTH-1];
      assign ramp_val   = base_ramp + DATA_WIDTH'(i);
      assign next_beat[i*DATA_WIDTH +: DATA_WIDTH] = mode_sh ? ramp_val : sine_val;
      assign unused_bits = ^{samp_phase[PHASE_WIDTH-ADDR_WIDTH-1:0],
                             product[2*DATA_WIDTH:2*DATA_WIDTH-1],
                             product[DATA_WIDTH-2:0]};
   end

   // Stream state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and beat-load decision; a held beat is never withdrawn.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               if (enable) begin
                  load = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Shadow configuration, consumed only when a beat is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_sh <= '0;
         amp_sh  <= UNITY_GAIN;
         mode_sh <= 1'b0;
      end else if (cfg_valid) begin
         freq_sh <= cfg_freq_word;
         amp_sh  <= cfg_amp;
         mode_sh <= cfg_mode;
      end
   end

   // Output beat register and generator state advance on each load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdata_q <= '0;
         phase_q <= '0;
         ramp_q  <= '0;
      end else if (load) begin
         tdata_q <= next_beat;
         phase_q <= base_phase + PHASE_WIDTH'(SAMPLES_PER_CYCLE) * freq_sh;
         ramp_q  <= base_ramp + DATA_WIDTH'(SAMPLES_PER_CYCLE);
      end
   end

   // Accepted-beat counter, free-running modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count <= '0;
      end else if (accept) begin
         beat_count <= beat_count + 32'd1;
      end
   end

   assign axis.s_axis_tdata  = tdata_q;
   assign axis.s_axis_tvalid = (state == RUN);

endmodule

// File: tb/tb_rfdc_dds_driver.sv
// Self-checking bench for rfdc_dds_driver: directed scenarios plus a random
// phase, all compared against a cycle-level reference model of the stream.
module tb_rfdc_dds_driver;
   localparam int DW  = 16;
   localparam int SPC = 5;
   localparam int LD  = 64;
   localparam int PW  = 32;

   logic           clk;
   logic           rst_n;
   logic           enable;
   logic           cfg_valid;
   logic [PW-1:0]  cfg_freq_word;
   logic [DW-1:0]  cfg_amp;
   logic           cfg_mode;
   logic [31:0]    beat_count;

   rfdc_dds_driver_if #(.DATA_WIDTH(DW), .SAMPLES_PER_CYCLE(SPC)) bus ();

   rfdc_dds_driver #(
      .DATA_WIDTH(DW), .SAMPLES_PER_CYCLE(SPC), .LUT_DEPTH(LD), .PHASE_WIDTH(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_freq_word(cfg_freq_word), .cfg_amp(cfg_amp), .cfg_mode(cfg_mode),
      .axis(bus), .beat_count(beat_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: sine table from the math definition, plus stream state.
   int                lut_m [LD];
   bit                m_run;
   logic [DW*SPC-1:0] m_tdata;
   logic [31:0]       m_count;
   logic [PW-1:0]     m_phase;
   logic [DW-1:0]     m_ramp;
   logic [PW-1:0]     m_freq;
   int                m_amp;
   bit                m_mode;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] time limit exceeded");
   end

   function automatic logic [DW-1:0] samp(input logic [DW*SPC-1:0] b, input int i);
      return b[i*DW +: DW];
   endfunction

   function automatic logic [DW*SPC-1:0] pack5(input int a0, input int a1, input int a2,
                                               input int a3, input int a4);
      return {DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
   endfunction

   // One beat from the rules: sample i at phase P+i*f, or ramp R+i.
   function automatic logic [DW*SPC-1:0] model_beat(input logic [PW-1:0] p, input logic [DW-1:0] r,
                                                    input logic [PW-1:0] f, input int amp, input bit mode);
      logic [DW*SPC-1:0] b;
      logic [PW-1:0]     ph;
      longint            prod;
      int                a;
      a = (amp > 32768) ? 32768 : amp;
      b = '0;
      for (int i = 0; i < SPC; i++) begin
         if (mode) begin
            b[i*DW +: DW] = r + DW'(i);
         end else begin
            ph   = p + PW'(i) * f;
            prod = longint'(lut_m[ph[31:26]]) * longint'(a);
            b[i*DW +: DW] = DW'(prod >>> 15);
         end
      end
      return b;
   endfunction

   task automatic model_reset();
      m_run   = 1'b0;
      m_tdata = '0;
      m_count = '0;
      m_phase = '0;
      m_ramp  = '0;
      m_freq  = '0;
      m_amp   = 32768;
      m_mode  = 1'b0;
   endtask

   // Advance one clock edge and let the model follow the same inputs.
   task automatic apply_stimulus();
      @(posedge clk);
      if (!m_run) begin
         if (enable) begin
            m_tdata = model_beat('0, '0, m_freq, m_amp, m_mode);
            m_phase = PW'(SPC) * m_freq;
            m_ramp  = DW'(SPC);
            m_run   = 1'b1;
         end
      end else if (bus.s_axis_tready) begin
         m_count = m_count + 32'd1;
         if (enable) begin
            m_tdata = model_beat(m_phase, m_ramp, m_freq, m_amp, m_mode);
            m_phase = m_phase + PW'(SPC) * m_freq;
            m_ramp  = m_ramp + DW'(SPC);
         end else begin
            m_run = 1'b0;
         end
      end
      if (cfg_valid) begin
         m_freq = cfg_freq_word;
         m_amp  = int'(cfg_amp);
         m_mode = cfg_mode;
      end
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [PW-1:0] f, input logic [DW-1:0] a, input logic m);
      cfg_valid     = 1'b1;
      cfg_freq_word = f;
      cfg_amp       = a;
      cfg_mode      = m;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      cfg_valid = 1'b0;
      cfg_freq_word = '0;
      cfg_amp = '0;
      cfg_mode = 1'b0;
      bus.s_axis_tready = 1'b0;
      model_reset();
      #3;
      checks++; if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", bus.s_axis_tvalid); end
      checks++; if (bus.s_axis_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", bus.s_axis_tdata); end
      checks++; if (beat_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", beat_count); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sine();
      logic [DW*SPC-1:0] exp_beat;
      set_cfg(32'h0400_0000, 16'd32768, 1'b0);
      apply_stimulus();
      enable = 1'b1;
      bus.s_axis_tready = 1'b1;
      apply_stimulus();
      exp_beat = pack5(0, 3211, 6392, 9511, 12539);
      checks++; if (bus.s_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL sine_tvalid: got %b expected 1", bus.s_axis_tvalid); end
      checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL sine_beat0: got %h expected %h", bus.s_axis_tdata, exp_beat); end
      for (int b = 1; b <= 12; b++) begin
         apply_stimulus();
         checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL sine_model beat %0d: got %h expected %h", b, bus.s_axis_tdata, m_tdata); end
         checks++; if (beat_count !== m_count) begin errors++; $display("[TB] FAIL sine_count beat %0d: got %0d expected %0d", b, beat_count, m_count); end
         if (b == 1) begin
            exp_beat = pack5(lut_m[5], lut_m[6], lut_m[7], lut_m[8], lut_m[9]);
            checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL sine_beat1: got %h expected %h", bus.s_axis_tdata, exp_beat); end
         end
         if (b == 12) begin
            exp_beat = pack5(lut_m[60], lut_m[61], lut_m[62], lut_m[63], lut_m[0]);
            checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL sine_beat12: got %h expected %h", bus.s_axis_tdata, exp_beat); end
            checks++; if (samp(bus.s_axis_tdata, 0) !== 16'(-12539)) begin errors++; $display("[TB] FAIL sine_lut60: got %0d expected -12539", $signed(samp(bus.s_axis_tdata, 0))); end
         end
      end
      checks++; if (beat_count !== 32'd12) begin errors++; $display("[TB] FAIL sine_count12: got %0d expected 12", beat_count); end
   endtask

   task automatic test_backpressure();
      logic [DW*SPC-1:0] held;
      held = m_tdata;
      bus.s_axis_tready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         apply_stimulus();
         checks++; if (bus.s_axis_tdata !== held) begin errors++; $display("[TB] FAIL bp_hold cycle %0d: got %h expected %h", c, bus.s_axis_tdata, held); end
         checks++; if (bus.s_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tvalid cycle %0d: got %b expected 1", c, bus.s_axis_tvalid); end
         checks++; if (beat_count !== 32'd12) begin errors++; $display("[TB] FAIL bp_count cycle %0d: got %0d expected 12", c, beat_count); end
      end
      bus.s_axis_tready = 1'b1;
      apply_stimulus();
      checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL bp_next: got %h expected %h", bus.s_axis_tdata, m_tdata); end
      checks++; if (samp(bus.s_axis_tdata, 0) !== 16'd3211) begin errors++; $display("[TB] FAIL bp_next_lut1: got %0d expected 3211", samp(bus.s_axis_tdata, 0)); end
   endtask

   task automatic test_gain();
      bus.s_axis_tready = 1'b1;
      enable = 1'b0;
      apply_stimulus();
      checks++; if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL gain_stop: got %b expected 0", bus.s_axis_tvalid); end
      set_cfg(32'h0400_0000, 16'd16384, 1'b0);
      apply_stimulus();
      enable = 1'b1;
      for (int b = 0; b <= 9; b++) begin
         apply_stimulus();
         checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL gain_model beat %0d: got %h expected %h", b, bus.s_axis_tdata, m_tdata); end
         if (b == 3) begin
            checks++; if (samp(bus.s_axis_tdata, 1) !== 16'd16383) begin errors++; $display("[TB] FAIL gain_half_pos: got %0d expected 16383", samp(bus.s_axis_tdata, 1)); end
         end
         if (b == 9) begin
            checks++; if (samp(bus.s_axis_tdata, 3) !== 16'(-16384)) begin errors++; $display("[TB] FAIL gain_half_neg: got %0d expected -16384", $signed(samp(bus.s_axis_tdata, 3))); end
         end
      end
      enable = 1'b0;
      apply_stimulus();
      set_cfg(32'h0400_0000, 16'd65535, 1'b0);
      apply_stimulus();
      enable = 1'b1;
      for (int b = 0; b <= 3; b++) apply_stimulus();
      checks++; if (samp(bus.s_axis_tdata, 1) !== 16'd32767) begin errors++; $display("[TB] FAIL gain_clamp: got %0d expected 32767", samp(bus.s_axis_tdata, 1)); end
   endtask

   task automatic test_ramp();
      logic [DW*SPC-1:0] exp_beat;
      bus.s_axis_tready = 1'b1;
      enable = 1'b0;
      apply_stimulus();
      set_cfg(32'h0400_0000, 16'd1234, 1'b1);
      apply_stimulus();
      enable = 1'b1;
      apply_stimulus();
      exp_beat = pack5(0, 1, 2, 3, 4);
      checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL ramp_beat0: got %h expected %h", bus.s_axis_tdata, exp_beat); end
      apply_stimulus();
      exp_beat = pack5(5, 6, 7, 8, 9);
      checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL ramp_beat1: got %h expected %h", bus.s_axis_tdata, exp_beat); end
      for (int b = 2; b <= 39321; b++) apply_stimulus();
      exp_beat = pack5(65533, 65534, 65535, 0, 1);
      checks++; if (bus.s_axis_tdata !== exp_beat) begin errors++; $display("[TB] FAIL ramp_wrap: got %h expected %h", bus.s_axis_tdata, exp_beat); end
      checks++; if (beat_count !== m_count) begin errors++; $display("[TB] FAIL ramp_count: got %0d expected %0d", beat_count, m_count); end
   endtask

   task automatic test_config_enable();
      logic [31:0] count_before;
      bus.s_axis_tready = 1'b1;
      enable = 1'b0;
      apply_stimulus();
      set_cfg(32'h0400_0000, 16'd32768, 1'b0);
      apply_stimulus();
      enable = 1'b1;
      apply_stimulus();
      apply_stimulus();
      set_cfg(32'h0800_0000, 16'd32768, 1'b0);
      apply_stimulus();
      checks++; if (samp(bus.s_axis_tdata, 1) !== DW'(lut_m[11])) begin errors++; $display("[TB] FAIL cfg_old_freq: got %0d expected %0d", samp(bus.s_axis_tdata, 1), lut_m[11]); end
      checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL cfg_old_model: got %h expected %h", bus.s_axis_tdata, m_tdata); end
      apply_stimulus();
      checks++; if (samp(bus.s_axis_tdata, 1) !== DW'(lut_m[17])) begin errors++; $display("[TB] FAIL cfg_new_freq: got %0d expected %0d", samp(bus.s_axis_tdata, 1), lut_m[17]); end
      bus.s_axis_tready = 1'b0;
      enable = 1'b0;
      count_before = m_count;
      for (int c = 0; c < 2; c++) begin
         apply_stimulus();
         checks++; if (bus.s_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL en_drop_hold_valid: got %b expected 1", bus.s_axis_tvalid); end
         checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL en_drop_hold_data: got %h expected %h", bus.s_axis_tdata, m_tdata); end
      end
      bus.s_axis_tready = 1'b1;
      apply_stimulus();
      checks++; if (beat_count !== count_before + 32'd1) begin errors++; $display("[TB] FAIL en_drop_accept: got %0d expected %0d", beat_count, count_before + 32'd1); end
      checks++; if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL en_drop_idle: got %b expected 0", bus.s_axis_tvalid); end
      apply_stimulus();
      checks++; if (beat_count !== count_before + 32'd1) begin errors++; $display("[TB] FAIL idle_count: got %0d expected %0d", beat_count, count_before + 32'd1); end
      enable = 1'b1;
      apply_stimulus();
      checks++; if (samp(bus.s_axis_tdata, 0) !== 16'd0) begin errors++; $display("[TB] FAIL restart_phase0: got %0d expected 0", samp(bus.s_axis_tdata, 0)); end
      checks++; if (samp(bus.s_axis_tdata, 1) !== DW'(lut_m[2])) begin errors++; $display("[TB] FAIL restart_step: got %0d expected %0d", samp(bus.s_axis_tdata, 1), lut_m[2]); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         enable = ($urandom_range(0, 9) != 0);
         bus.s_axis_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) set_cfg($urandom(), DW'($urandom()), ($urandom_range(0, 3) == 0));
         apply_stimulus();
         checks++; if (bus.s_axis_tvalid !== m_run) begin errors++; $display("[TB] FAIL rand_tvalid cycle %0d: got %b expected %b", c, bus.s_axis_tvalid, m_run); end
         checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL rand_tdata cycle %0d: got %h expected %h", c, bus.s_axis_tdata, m_tdata); end
         checks++; if (beat_count !== m_count) begin errors++; $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", c, beat_count, m_count); end
      end
   endtask

   task automatic test_mid_reset();
      enable = 1'b1;
      bus.s_axis_tready = 1'b1;
      for (int c = 0; c < 3; c++) apply_stimulus();
      bus.s_axis_tready = 1'b0;
      apply_stimulus();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.s_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid: got %b expected 0", bus.s_axis_tvalid); end
      checks++; if (bus.s_axis_tdata !== '0) begin errors++; $display("[TB] FAIL midrst_tdata: got %h expected 0", bus.s_axis_tdata); end
      checks++; if (beat_count !== 32'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", beat_count); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.s_axis_tready = 1'b1;
      apply_stimulus();
      checks++; if (bus.s_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL postrst_tvalid: got %b expected 1", bus.s_axis_tvalid); end
      checks++; if (bus.s_axis_tdata !== m_tdata) begin errors++; $display("[TB] FAIL postrst_cfg_default: got %h expected %h", bus.s_axis_tdata, m_tdata); end
   endtask

   // Scenario sequence.
   initial begin
      for (int k = 0; k < LD; k++) begin
         lut_m[k] = $rtoi($sin(2.0 * 3.14159265358979323846 * k / LD) * 32767.0);
      end
      test_reset();
      test_sine();
      test_backpressure();
      test_gain();
      test_ramp();
      test_config_enable();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
